// File: rtl/blk_0aa684.sv
// blk_0aa684: 8-entry register file with two combinational read ports and one synchronous write port
module blk_0aa684 #(
  parameter int width = 8
) (
  input  logic [width-1:0] write_data,
  input  logic [2:0]       read_port_1,
  input  logic [2:0]       read_port_2,
  input  logic [2:0]       write_port,
  input  logic             write_enable,
  input  logic             reset,
  input  logic             clk,
  output logic [width-1:0] read_data_1,
  output logic [width-1:0] read_data_2
);
  logic [width-1:0] regs_q [8];
  logic [width-1:0] regs_d [8];
  always_comb begin
    for (int i = 0; i < 8; i++)
      regs_d[i] = (write_enable && write_port == 3'(i)) ? write_data : regs_q[i];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    else
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
  end
  // No write bypass: reads always see the committed contents
  assign read_data_1 = regs_q[read_port_1];
  assign read_data_2 = regs_q[read_port_2];
endmodule

// File: tb/tb_blk_0aa684.sv
// tb_blk_0aa684: table-driven and randomized checks of blk_0aa684 against an array model
module tb_blk_0aa684;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] write_data = '0;
  logic [2:0] read_port_1 = '0, read_port_2 = '0, write_port = '0;
  logic       write_enable = 1'b0;
  logic [7:0] read_data_1, read_data_2;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] mem [8];

  blk_0aa684 #(.width(8)) dut (
    .write_data(write_data), .read_port_1(read_port_1), .read_port_2(read_port_2),
    .write_port(write_port), .write_enable(write_enable), .reset(reset), .clk(clk),
    .read_data_1(read_data_1), .read_data_2(read_data_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] wp;
    logic [7:0] wd;
    logic [2:0] rp1, rp2;
    logic [7:0] pre1, pre2, post1, post2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset && write_enable) mem[write_port] = write_data;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mem[i] = '0;
  endtask

  task automatic check_model(input string tag);
    #1;
    chk({tag, "_rd1"}, read_data_1, mem[read_port_1]);
    chk({tag, "_rd2"}, read_data_2, mem[read_port_2]);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd0, 8'd100, 3'd0, 3'd1, 8'd0,   8'd0,   8'd100, 8'd0};
    vecs[1] = '{1'b1, 3'd1, 8'd50,  3'd0, 3'd1, 8'd100, 8'd0,   8'd100, 8'd50};
    vecs[2] = '{1'b0, 3'd2, 8'd100, 3'd2, 3'd0, 8'd0,   8'd100, 8'd0,   8'd100};
    vecs[3] = '{1'b0, 3'd2, 8'd100, 3'd1, 3'd2, 8'd50,  8'd0,   8'd50,  8'd0};
    vecs[4] = '{1'b1, 3'd5, 8'hAA,  3'd5, 3'd5, 8'd0,   8'd0,   8'hAA,  8'hAA};
    vecs[5] = '{1'b1, 3'd5, 8'h55,  3'd5, 3'd5, 8'hAA,  8'hAA,  8'h55,  8'h55};
    vecs[6] = '{1'b0, 3'd5, 8'd0,   3'd0, 3'd1, 8'd100, 8'd50,  8'd100, 8'd50};
    clear_model();

    // Reset asserted asynchronously, then writes attempted while held
    #2 reset = 1'b0;
    #1;
    chk("reset_rd1", read_data_1, 8'd0);
    chk("reset_rd2", read_data_2, 8'd0);
    write_enable = 1'b1; write_port = 3'd4; write_data = 8'hF0;
    tick();
    reset = 1'b1; write_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_port_1 = 3'(i); read_port_2 = 3'(7 - i);
      #1;
      chk("post_reset_rd1", read_data_1, 8'd0);
      chk("post_reset_rd2", read_data_2, 8'd0);
    end

    // Directed table: old value before the edge, new value after it
    foreach (vecs[k]) begin
      write_enable = vecs[k].we; write_port = vecs[k].wp; write_data = vecs[k].wd;
      read_port_1 = vecs[k].rp1; read_port_2 = vecs[k].rp2;
      #1;
      chk($sformatf("vec%0d_pre1", k), read_data_1, vecs[k].pre1);
      chk($sformatf("vec%0d_pre2", k), read_data_2, vecs[k].pre2);
      tick();
      chk($sformatf("vec%0d_post1", k), read_data_1, vecs[k].post1);
      chk($sformatf("vec%0d_post2", k), read_data_2, vecs[k].post2);
    end
    write_enable = 1'b0;

    // Mid-cycle reset clears immediately and swallows a pending write
    read_port_1 = 3'd0; read_port_2 = 3'd1;
    #2 reset = 1'b0;
    #1;
    chk("midreset_rd1", read_data_1, 8'd0);
    chk("midreset_rd2", read_data_2, 8'd0);
    write_enable = 1'b1; write_port = 3'd3; write_data = 8'd20;
    tick();
    write_enable = 1'b0; reset = 1'b1;
    clear_model();
    read_port_1 = 3'd3; read_port_2 = 3'd0;
    #1;
    chk("ignored_write_e3", read_data_1, 8'd0);
    chk("cleared_e0", read_data_2, 8'd0);

    // Distinct value per entry, then opposing sweeps
    for (int i = 0; i < 8; i++) begin
      write_enable = 1'b1; write_port = 3'(i); write_data = 8'(i * 17);
      tick();
    end
    write_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_port_1 = 3'(i); read_port_2 = 3'(7 - i);
      #1;
      chk($sformatf("sweep_rd1_%0d", i), read_data_1, 8'(i * 17));
      chk($sformatf("sweep_rd2_%0d", 7 - i), read_data_2, 8'((7 - i) * 17));
    end

    // Randomized traffic against the array model, with occasional resets
    for (int n = 0; n < 400; n++) begin
      write_enable = 1'($urandom_range(0, 1));
      write_port = 3'($urandom_range(0, 7));
      write_data = 8'($urandom);
      read_port_1 = 3'($urandom_range(0, 7));
      read_port_2 = ($urandom_range(0, 3) == 0) ? read_port_1 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        clear_model();
        check_model("rand_reset");
        tick();
        reset = 1'b1;
        check_model("rand_after_reset");
      end else begin
        check_model("rand_pre");
        tick();
        check_model("rand_post");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/blk_0aa684.md
Name: eight_by_eight_reg_file_with_two_reads_and_one_write

Overview:
- 8-entry register file with two independent combinational read ports and one synchronous write port.
- Entry width is parameterised, default 8 bits.
- Serves as general-purpose operand storage for a simple datapath: two source operands are read per cycle and one result is written back.

Parameters:
- width, 8, bit width of each register entry and of the data ports.

Ports:
- clk  input  1  system clock; all writes take effect on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all entries.
- write_data  input  width  data to store.
- read_port_1  input  3  address for read port 1.
- read_port_2  input  3  address for read port 2.
- write_port  input  3  address for the write port.
- write_enable  input  1  active-high write strobe.
- read_data_1  output  width  contents of entry read_port_1.
- read_data_2  output  width  contents of entry read_port_2.

Behaviour:
- Positional port order (mandatory for existing instantiations): write_data, read_port_1, read_port_2, write_port, write_enable, reset, clk, read_data_1, read_data_2.
- Storage: 8 entries of width bits, addressed 0..7. No hardwired-zero entry.
- Reset:
  - reset low clears all 8 entries to 0 immediately, independent of clk.
  - While reset is held low, writes are ignored and both read outputs are 0.
  - On reset deassertion, entries stay 0 until written.
  - If reset is asserted mid-operation, any pending write is lost.
- Write:
  - On a rising clk edge with reset high and write_enable=1, entry[write_port] <= write_data.
  - write_enable=0: no entry changes.
  - Only the addressed entry changes.
- Read:
  - Purely combinational. read_data_1 = entry[read_port_1] and read_data_2 = entry[read_port_2], with zero-cycle latency from an address change.
  - Both ports may address the same entry; both then return identical data.
- Read-during-write to the same address:
  - Before the edge, the read returns the old value (no bypass).
  - After the edge, the read returns the new value.
  - Write-to-read latency is therefore one clock edge.
- Full range of addresses 0..7 is valid; no out-of-range case exists.
- Data is stored unmodified; write_data is exactly width bits, so no truncation or extension occurs.
- No X may appear on the outputs after the first reset.

Test Plan:
1. Assert reset low, release, then read ports 0 and 7 -> read_data_1 = read_data_2 = 0 for every address.
2. write_enable=1, write 100 to entry 0 at edge 1 and 50 to entry 1 at edge 2, with read_port_1=0 and read_port_2=1 -> after edge 2, read_data_1=100 and read_data_2=50. Before edge 1, read_data_1 = 0.
3. write_enable=0, write_data=100, write_port=2 for several edges -> entry 2 stays 0 and entries 0/1 are unchanged (100/50).
4. After scenario 2, drive reset low between clock edges -> read_data_1 and read_data_2 go to 0 immediately. Attempt a write of 20 to entry 3 while reset is low -> entry 3 still reads 0 after release.
5. Write 0xAA to entry 5, then at the next edge write 0x55 to entry 5 with both read ports on 5 -> both outputs read 0xAA until that edge and 0x55 after it.
6. Write a distinct value (i*17) to each of entries 0..7, then sweep read_port_1 upward and read_port_2 downward -> every output matches its stored value; no aliasing between addresses.
